// File: rtl/layer_norm_pkg.sv
// Shared types and default sizes for the LayerNorm engine and its sequencer.
package layer_norm_pkg;

  localparam int unsigned LN_DATA_WIDTH = 16;
  localparam int unsigned LN_EMBED_DIM  = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ln_state_e;

  typedef logic signed [LN_DATA_WIDTH-1:0] ln_elem_t;

endpackage

// File: rtl/ln_vec_serializer.sv
// Holds a captured vector and replays it one element per valid/ready beat, index 0 first.
module ln_vec_serializer
  import layer_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = LN_DATA_WIDTH,
  parameter int unsigned EMBED_DIM  = LN_EMBED_DIM
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load,
  input  logic [0:EMBED_DIM-1][DATA_WIDTH-1:0] load_vec,
  input  logic                                 active,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic                                 done_c
);

  localparam int unsigned       IDX_W    = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(EMBED_DIM - 1);

  logic [0:EMBED_DIM-1][DATA_WIDTH-1:0] out_reg_q;
  logic [IDX_W-1:0]                     idx_q;
  logic                                 beat_c;

  assign beat_c    = active && out_ready;
  assign out_valid = active;
  assign out_data  = out_reg_q[idx_q];
  assign out_last  = active && (idx_q == IDX_LAST);
  assign done_c    = beat_c && (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg_q <= '0;
    end else if (load) begin
      out_reg_q <= load_vec;
    end
  end

  // Index only moves on accepted beats, so data/last hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (beat_c) begin
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/layer_norm_sequencer.sv
// Streams one token into the LayerNorm engine, runs its start/done handshake and streams the result out.
// Optional WAIT watchdog enabled by defining LN_SEQ_TIMEOUT_EN.
module layer_norm_sequencer
  import layer_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = LN_DATA_WIDTH,
  parameter int unsigned EMBED_DIM      = LN_EMBED_DIM,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 ln_start,
  output logic [0:EMBED_DIM-1][DATA_WIDTH-1:0] ln_activation,
  input  logic                                 ln_done,
  input  logic [0:EMBED_DIM-1][DATA_WIDTH-1:0] ln_normalized,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 timeout_err
);

  localparam int unsigned       IDX_W    = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(EMBED_DIM - 1);

  ln_state_e                            state_q, state_d;
  logic [IDX_W-1:0]                     fill_idx_q;
  logic [0:EMBED_DIM-1][DATA_WIDTH-1:0] act_q;
  logic                                 in_fire_c;
  logic                                 capture_c;
  logic                                 expire_c;
  logic                                 drain_done_c;
  logic [0:EMBED_DIM-1][DATA_WIDTH-1:0] load_vec_c;

  assign in_fire_c     = in_valid && (state_q == FILL);
  assign capture_c     = ln_done && (state_q == WAIT);
  assign load_vec_c    = capture_c ? ln_normalized : '0;
  assign ln_activation = act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    ln_start = 1'b0;
    busy     = 1'b1;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_fire_c && (fill_idx_q == IDX_LAST)) state_d = START;
      end
      START: begin
        ln_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (capture_c || expire_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done_c) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Activation register only changes on accepted FILL beats, so it is stable through START/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_idx_q <= '0;
      act_q      <= '0;
    end else if (in_fire_c) begin
      act_q[fill_idx_q] <= in_data;
      fill_idx_q        <= (fill_idx_q == IDX_LAST) ? '0 : fill_idx_q + IDX_W'(1);
    end
  end

  ln_vec_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .EMBED_DIM  (EMBED_DIM)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture_c || expire_c),
    .load_vec  (load_vec_c),
    .active    (state_q == DRAIN),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done_c    (drain_done_c)
  );

`ifdef LN_SEQ_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // A done on the expiry cycle wins, so expiry is qualified with !ln_done.
  assign expire_c    = (state_q == WAIT) && !ln_done &&
                       (wait_cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if ((state_q == WAIT) && !ln_done) begin
        wait_cnt_q <= wait_cnt_q + TMR_W'(1);
      end else begin
        wait_cnt_q <= '0;
      end
      if (expire_c) timeout_q <= 1'b1;
    end
  end
`else
  logic timeout_cfg_unused;

  assign timeout_cfg_unused = (TIMEOUT_CYCLES == 0);
  assign expire_c           = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_layer_norm_sequencer.sv
// Directed bench for layer_norm_sequencer with a delayed-done engine responder.
module tb_layer_norm_sequencer;

  typedef logic [0:7][15:0] vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        ln_start;
  vec_t        ln_activation;
  logic        ln_done;
  vec_t        ln_normalized;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        timeout_err;

  int checks;
  int failures;

  vec_t resp_tab [0:1];
  logic resp_sel;
  int   nstart;
  bit   resp_en;
  int   resp_delay;
  logic resp_done;
  logic stray_done;

  logic [15:0] got_data [0:31];
  logic        got_last [0:31];
  int          got_n;
  int          first_cyc;
  int          stall_bad;
  int          inrdy_bad;

  vec_t va, vr, vb, vrb, vc, vz;

  assign ln_done       = resp_done | stray_done;
  assign ln_normalized = resp_tab[resp_sel];

  layer_norm_sequencer #(
    .DATA_WIDTH     (16),
    .EMBED_DIM      (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .ln_start      (ln_start),
    .ln_activation (ln_activation),
    .ln_done       (ln_done),
    .ln_normalized (ln_normalized),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model: pulses done resp_delay cycles after seeing ln_start.
  initial begin
    bit pend;
    int cnt;
    pend      = 1'b0;
    cnt       = 0;
    resp_done = 1'b0;
    resp_sel  = 1'b0;
    nstart    = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            resp_done = 1'b1;
            pend      = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (ln_start === 1'b1) begin
          resp_sel = nstart[0];
          nstart++;
          if (resp_en) begin
            pend = 1'b1;
            cnt  = resp_delay - 1;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog sim_time=%0t required=finish_before_limit", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7);
    vec_t v;
    v[0] = 16'(a0); v[1] = 16'(a1); v[2] = 16'(a2); v[3] = 16'(a3);
    v[4] = 16'(a4); v[5] = 16'(a5); v[6] = 16'(a6); v[7] = 16'(a7);
    return v;
  endfunction

  task automatic send(input vec_t v, input int first, input int n);
    int w;
    for (int i = first; i < first + n; i++) begin
      w        = 0;
      in_valid = 1'b1;
      in_data  = v[i];
      while (in_ready !== 1'b1 && w < 500) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (w >= 500) begin
        checks++;
        failures++;
        $display("FAIL send_wait elem=%0d in_ready=%b required=1", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input bit pat, output bit tout);
    int          cyc;
    logic [15:0] pd;
    logic        pl;
    bit          hp;
    cyc = 0; hp = 1'b0; pd = '0; pl = 1'b0;
    got_n = 0; first_cyc = -1; stall_bad = 0; inrdy_bad = 0; tout = 1'b0;
    while (got_n < n) begin
      if (cyc >= 3000) begin
        tout = 1'b1;
        break;
      end
      out_ready = pat ? (cyc % 3 == 0) : 1'b1;
      if (hp && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) stall_bad++;
      hp = 1'b0;
      if (out_valid === 1'b1) begin
        if (in_ready !== 1'b0) inrdy_bad++;
        if (out_ready) begin
          if (first_cyc < 0) first_cyc = cyc;
          got_data[got_n] = out_data;
          got_last[got_n] = out_last;
          got_n++;
        end else begin
          hp = 1'b1;
          pd = out_data;
          pl = out_last;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (ln_start !== 1'b0) begin failures++; $display("FAIL reset_ln_start got=%b exp=0", ln_start); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    checks++; if (ln_activation !== '0) begin failures++; $display("FAIL reset_activation got=%h exp=0", ln_activation); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int s0;
    bit to;
    s0 = nstart;
    resp_delay = 6;
    resp_tab[0] = vr; resp_tab[1] = vr;
    send(va, 0, 8);
    checks++; if (ln_start !== 1'b1) begin failures++; $display("FAIL basic_start_t1 got=%b exp=1", ln_start); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_start got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    @(posedge clk);
    #1;
    checks++; if (ln_start !== 1'b0) begin failures++; $display("FAIL basic_start_single got=%b exp=0", ln_start); end
    checks++; if (ln_activation !== va) begin failures++; $display("FAIL basic_activation got=%h exp=%h", ln_activation, va); end
    drain(8, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL basic_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== vr[i]) begin
        failures++;
        $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, $signed(got_data[i]), $signed(vr[i]));
      end
      checks++;
      if (got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL basic_last[%0d] got=%b exp=%b", i, got_last[i], (i == 7));
      end
    end
    checks++; if (first_cyc != 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", first_cyc); end
    checks++; if (nstart - s0 != 1) begin failures++; $display("FAIL basic_start_count got=%0d exp=1", nstart - s0); end
  endtask

  task automatic test_backpressure();
    bit to;
    resp_tab[0] = vr; resp_tab[1] = vr;
    send(va, 0, 8);
    drain(8, 1'b1, to);
    checks++; if (to) begin failures++; $display("FAIL bp_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== vr[i] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL bp_beat[%0d] got=%0d/%b exp=%0d/%b", i, $signed(got_data[i]), got_last[i],
                 $signed(vr[i]), (i == 7));
      end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (inrdy_bad != 0) begin failures++; $display("FAIL bp_in_ready_drain got=%0d exp=0", inrdy_bad); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_after_last got=valid%b/ready%b exp=valid0/ready1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got=%b exp=0", out_valid); end
  endtask

  task automatic test_stray_done();
    int s0;
    bit to;
    s0 = nstart;
    resp_tab[0] = vr; resp_tab[1] = vr;
    send(vc, 0, 3);
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL stray_state got=busy%b/ready%b/valid%b exp=busy0/ready1/valid0", busy, in_ready, out_valid);
    end
    resp_tab[0] = vz; resp_tab[1] = vz;
    send(vc, 3, 5);
    @(posedge clk);
    #1;
    checks++; if (ln_activation !== vc) begin failures++; $display("FAIL stray_activation got=%h exp=%h", ln_activation, vc); end
    drain(8, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL stray_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== 16'd0) begin failures++; $display("FAIL stray_data[%0d] got=%0d exp=0", i, $signed(got_data[i])); end
    end
    checks++; if (nstart - s0 != 1) begin failures++; $display("FAIL stray_start_count got=%0d exp=1", nstart - s0); end
  endtask

  task automatic test_reset_mid();
    bit to;
    resp_tab[0] = vr; resp_tab[1] = vr;
    send(va, 0, 8);
    drain(4, 1'b0, to);
    checks++; if (to || got_data[3] !== vr[3]) begin
      failures++; $display("FAIL rstmid_pre got=%0d exp=%0d", $signed(got_data[3]), $signed(vr[3]));
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_in_drain got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++; $display("FAIL rstmid_out got=valid%b/last%b exp=valid0/last0", out_valid, out_last);
    end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_state got=ready%b/busy%b exp=ready1/busy0", in_ready, busy);
    end
    checks++; if (ln_activation !== '0) begin failures++; $display("FAIL rstmid_activation got=%h exp=0", ln_activation); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resp_tab[0] = vrb; resp_tab[1] = vrb;
    send(vb, 0, 8);
    @(posedge clk);
    #1;
    checks++; if (ln_activation !== vb) begin failures++; $display("FAIL rstmid_next_act got=%h exp=%h", ln_activation, vb); end
    drain(8, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== vrb[i] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL rstmid_beat[%0d] got=%0d/%b exp=%0d/%b", i, $signed(got_data[i]), got_last[i],
                 $signed(vrb[i]), (i == 7));
      end
    end
  endtask

  task automatic test_long_latency();
    bit to;
    resp_delay  = 64;
    resp_tab[0] = vrb; resp_tab[1] = vrb;
    send(va, 0, 8);
    drain(8, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL longlat_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== vrb[i]) begin
        failures++; $display("FAIL longlat_data[%0d] got=%0d exp=%0d", i, $signed(got_data[i]), $signed(vrb[i]));
      end
    end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL longlat_timeout_err got=%b exp=0", timeout_err); end
    resp_delay = 6;
  endtask

`ifdef LN_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    resp_en     = 1'b0;
    resp_tab[0] = vr; resp_tab[1] = vr;
    send(va, 0, 8);
    repeat (64) begin
      @(posedge clk);
      #1;
    end
    checks++; if (timeout_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL tmo_early got=err%b/valid%b exp=err0/valid0", timeout_err, out_valid);
    end
    @(posedge clk);
    #1;
    checks++; if (timeout_err !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL tmo_expire got=err%b/valid%b exp=err1/valid1", timeout_err, out_valid);
    end
    drain(8, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL tmo_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== 16'd0) begin failures++; $display("FAIL tmo_data[%0d] got=%0d exp=0", i, $signed(got_data[i])); end
    end
    resp_en     = 1'b1;
    resp_tab[0] = vrb; resp_tab[1] = vrb;
    send(vb, 0, 8);
    drain(8, 1'b0, to);
    checks++; if (to || got_data[7] !== vrb[7] || got_data[0] !== vrb[0]) begin
      failures++; $display("FAIL tmo_next_token got=%0d exp=%0d", $signed(got_data[0]), $signed(vrb[0]));
    end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    bit to;
    resp_en     = 1'b0;
    resp_tab[0] = vr; resp_tab[1] = vr;
    send(va, 0, 8);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL nowd_wait got=busy%b/valid%b/err%b exp=busy1/valid0/err0", busy, out_valid, timeout_err);
    end
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    drain(8, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL nowd_drain_timeout got=%0d_beats exp=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== vr[i]) begin
        failures++; $display("FAIL nowd_data[%0d] got=%0d exp=%0d", i, $signed(got_data[i]), $signed(vr[i]));
      end
    end
    resp_en = 1'b1;
  endtask
`endif

  task automatic test_back_to_back();
    int base;
    bit to;
    base = nstart;
    resp_tab[base % 2]       = vr;
    resp_tab[1 - (base % 2)] = vrb;
    fork
      begin
        send(va, 0, 8);
        send(vb, 0, 8);
      end
      begin
        drain(16, 1'b0, to);
      end
    join
    checks++; if (to) begin failures++; $display("FAIL b2b_drain_timeout got=%0d_beats exp=16", got_n); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== ((i < 8) ? vr[i % 8] : vrb[i % 8]) || got_last[i] !== (i % 8 == 7)) begin
        failures++;
        $display("FAIL b2b_beat[%0d] got=%0d/%b exp=%0d/%b", i, $signed(got_data[i]), got_last[i],
                 $signed((i < 8) ? vr[i % 8] : vrb[i % 8]), (i % 8 == 7));
      end
    end
    checks++; if (nstart - base != 2) begin failures++; $display("FAIL b2b_start_count got=%0d exp=2", nstart - base); end
    checks++; if (inrdy_bad != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", inrdy_bad); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    stray_done = 1'b0;
    resp_en    = 1'b1;
    resp_delay = 6;
    va  = mk(5, 3, 3, 4, -1, 0, 2, 9);
    vr  = mk(1, 0, 0, 0, -2, -1, 0, 3);
    vb  = mk(-32768, 32767, 1, -1, 256, -256, 7, 0);
    vrb = mk(32767, -32768, -7, 100, 0, 1, -1, 12);
    vc  = mk(50, 50, 50, 50, 50, 50, 50, 50);
    vz  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    resp_tab[0] = vz;
    resp_tab[1] = vz;

    test_reset();
    test_basic();
    test_backpressure();
    test_stray_done();
    test_reset_mid();
    test_long_latency();
    test_timeout();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
